uart_rx_control: RTL and testbench
==================================

UART_RX_CONTROL -- requirements
Module: uart_rx_control

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50000000, meaning the globalclock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, meaning the serial bit rate.
REQ-003 SHALL have parameter TIMEOUT_BITS, default 20, meaning the inter-byte idle limit in bit times.
REQ-004 SHALL have port globalclock, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port uart_rx, input, 1 bit: asynchronous serial line, idle high, 8N1 framing, LSB first.
REQ-007 SHALL have port rx_data, output, 8 bits: the last received byte.
REQ-008 SHALL have port rx_valid, output, 1 bit: one-cycle pulse when rx_data is updated.
REQ-009 SHALL have port frame_err, output, 1 bit: one-cycle pulse when a stop bit is sampled low.
REQ-010 SHALL have port word_data, output, 24 bits: the assembled 3-byte word.
REQ-011 SHALL have port word_valid, output, 1 bit: one-cycle pulse when word_data is updated.
REQ-012 SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-013 SHALL compute CPB = CLK_FREQ/BAUD (integer division; 434 at defaults) and HALF = CPB/2 (217).
REQ-014 SHALL pass uart_rx through a 2-flop synchronizer; all decoding SHALL use the synchronized signal rx_s.
REQ-015 SHALL implement the FSM states IDLE, START, DATA, STOP and WAIT_HIGH.
REQ-016 IDLE: on a synchronized falling edge (rx_s previous value 1, current value 0), SHALL clear the bit timer and enter START.
REQ-017 START: after HALF cycles SHALL sample rx_s; if 0, enter DATA; if 1, treat as a glitch, return to IDLE and produce no output.
REQ-018 DATA: SHALL sample rx_s every CPB cycles, 8 samples, shifting LSB first; after the 8th sample SHALL enter STOP.
REQ-019 STOP, CPB cycles after the last data sample, sampled bit = 1: SHALL load rx_data, pulse rx_valid on the next cycle, and enter IDLE.
REQ-020 STOP, sampled bit = 0: SHALL pulse frame_err, leave rx_data unchanged, produce no rx_valid, and enter WAIT_HIGH.
REQ-021 WAIT_HIGH: SHALL remain until rx_s = 1, then enter IDLE; a low line (break) SHALL NOT start a new frame.
REQ-022 SHALL use a bit timer wide enough for CPB-1 and a 3-bit data-bit index; the timer SHALL restart at 0 on each sample.
REQ-023 Word assembler: a 2-bit byte_cnt SHALL run 0 -> 1 -> 2; the byte taken at byte_cnt=0 SHALL go to word_data[23:16], at 1 to [15:8], at 2 to [7:0].
REQ-024 On the rx_valid pulse at byte_cnt=2: SHALL update word_data and pulse word_valid in the same cycle as rx_valid, then clear byte_cnt to 0.
REQ-025 word_data SHALL hold its value between updates; partially assembled bytes SHALL NOT be visible on word_data.
REQ-026 A frame_err pulse SHALL clear byte_cnt to 0 and discard the partial word.
REQ-027 SHALL use an idle counter while byte_cnt != 0; it SHALL reset on every rx_valid, and on reaching TIMEOUT_BITS*CPB cycles SHALL clear byte_cnt without pulsing any output.
REQ-028 If a timeout and an rx_valid occur in the same cycle, rx_valid SHALL win: the byte is stored and byte_cnt advances.
REQ-029 rx_valid, frame_err and word_valid SHALL never be high for more than one consecutive cycle; rx_valid and frame_err SHALL be mutually exclusive.

Reset
REQ-030 On rst = 1 (asynchronous): FSM = IDLE; synchronizer flops = 1; rx_data = 0x00, word_data = 0x000000; rx_valid = frame_err = word_valid = busy = 0; byte_cnt, bit timer, bit index and idle counter = 0.
REQ-031 When rst is asserted mid-frame, the partial byte SHALL be discarded; after release, decoding SHALL resume only on a fresh falling edge.

Verification
REQ-032 Send byte 0xA5 at 115200 baud -> rx_data = 0xA5, exactly one rx_valid pulse, frame_err = 0, busy low after the stop-bit sample.
REQ-033 Send bytes 0x12, 0x34, 0x56 back to back -> three rx_valid pulses, word_data = 0x123456, one word_valid pulse coincident with the third rx_valid.
REQ-034 Drive a low pulse of 100 cycles (shorter than HALF) on an idle line -> no rx_valid, no frame_err, FSM back in IDLE.
REQ-035 Send 0x12, then 0x34 with the stop bit forced to 0, then 0x56 0x78 0x9A -> one frame_err pulse, byte_cnt cleared, final word_data = 0x56789A.
REQ-036 Send 0xAB, 0xCD, idle 25 bit times, then 0x01 0x02 0x03 -> no word_valid for the first pair, then word_data = 0x010203.
REQ-037 Assert rst during data bit 4 of 0xFF, release, then send 0x3C -> no output for the aborted byte, then rx_data = 0x3C with a single rx_valid.

Source files
------------

// File: rtl/uart_rx_control.sv
// 8N1 UART receiver with 3-byte word assembler; rx_valid/frame_err one cycle after the stop sample,
// word_valid coincident with the third rx_valid; no backpressure, outputs are single-cycle pulses.
module uart_rx_control #(
    parameter int CLK_FREQ     = 50000000,
    parameter int BAUD         = 115200,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic        globalclock,
    input  logic        rst,
    input  logic        uart_rx,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    output logic        frame_err,
    output logic [23:0] word_data,
    output logic        word_valid,
    output logic        busy
);

    localparam int CPB    = CLK_FREQ / BAUD;
    localparam int HALF   = CPB / 2;
    localparam int TW     = (CPB > 1) ? $clog2(CPB) : 1;
    localparam int TO_CYC = TIMEOUT_BITS * CPB;
    localparam int IW     = $clog2(TO_CYC + 1);
    localparam logic [TW-1:0] CPB_LAST  = TW'(CPB - 1);
    localparam logic [TW-1:0] HALF_LAST = TW'(HALF - 1);
    localparam logic [IW-1:0] TO_LAST   = IW'(TO_CYC - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

    state_t          state, state_nxt;
    logic            rx_meta, rx_s, rx_prev;
    logic [TW-1:0]   timer, timer_nxt;
    logic [2:0]      bit_idx, bit_idx_nxt;
    logic [7:0]      shreg, shreg_nxt;
    logic            byte_done, stop_bad;
    logic [1:0]      byte_cnt;
    logic [15:0]     word_hold;
    logic [IW-1:0]   idle_cnt;

    // rx_prev gives the previous synchronized value for falling-edge detection
    always_ff @(posedge globalclock or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
        end
    end

    always_comb begin
        state_nxt   = state;
        timer_nxt   = timer + 1'b1;
        bit_idx_nxt = bit_idx;
        shreg_nxt   = shreg;
        byte_done   = 1'b0;
        stop_bad    = 1'b0;
        case (state)
            IDLE: begin
                timer_nxt = '0;
                if (rx_prev && !rx_s) state_nxt = START;
            end
            START: begin
                if (timer == HALF_LAST) begin
                    timer_nxt   = '0;
                    bit_idx_nxt = '0;
                    state_nxt   = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (timer == CPB_LAST) begin
                    timer_nxt   = '0;
                    shreg_nxt   = {rx_s, shreg[7:1]};
                    bit_idx_nxt = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) state_nxt = STOP;
                end
            end
            STOP: begin
                if (timer == CPB_LAST) begin
                    timer_nxt = '0;
                    if (rx_s) begin
                        byte_done = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        stop_bad  = 1'b1;
                        state_nxt = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                timer_nxt = '0;
                if (rx_s) state_nxt = IDLE;
            end
            default: begin
                timer_nxt = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge globalclock or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            timer     <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            timer     <= timer_nxt;
            bit_idx   <= bit_idx_nxt;
            shreg     <= shreg_nxt;
            rx_valid  <= byte_done;
            frame_err <= stop_bad;
            if (byte_done) rx_data <= shreg;
        end
    end

    // A completed byte takes priority over the inter-byte timeout
    always_ff @(posedge globalclock or posedge rst) begin
        if (rst) begin
            byte_cnt   <= '0;
            word_hold  <= '0;
            word_data  <= '0;
            word_valid <= 1'b0;
            idle_cnt   <= '0;
        end else begin
            word_valid <= 1'b0;
            if (byte_done) begin
                idle_cnt <= '0;
                case (byte_cnt)
                    2'd0: begin
                        word_hold[15:8] <= shreg;
                        byte_cnt        <= 2'd1;
                    end
                    2'd1: begin
                        word_hold[7:0] <= shreg;
                        byte_cnt       <= 2'd2;
                    end
                    default: begin
                        word_data  <= {word_hold, shreg};
                        word_valid <= 1'b1;
                        byte_cnt   <= 2'd0;
                    end
                endcase
            end else if (stop_bad) begin
                byte_cnt <= '0;
                idle_cnt <= '0;
            end else if (byte_cnt != 2'd0) begin
                if (idle_cnt == TO_LAST) begin
                    byte_cnt <= '0;
                    idle_cnt <= '0;
                end else begin
                    idle_cnt <= idle_cnt + 1'b1;
                end
            end else begin
                idle_cnt <= '0;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_control.sv
// Directed bench for uart_rx_control: frame-level model of bytes, words and framing errors,
// checked on every output pulse, plus literal expectations per scenario.
module tb_uart_rx_control;

    localparam int CLK_FREQ = 4620000;
    localparam int BAUD     = 115200;
    localparam int TOB      = 20;
    localparam int CPB      = CLK_FREQ / BAUD;

    logic        globalclock = 1'b0;
    logic        rst = 1'b1;
    logic        uart_rx = 1'b1;
    logic [7:0]  rx_data;
    logic        rx_valid, frame_err, word_valid, busy;
    logic [23:0] word_data;

    uart_rx_control #(
        .CLK_FREQ(CLK_FREQ),
        .BAUD(BAUD),
        .TIMEOUT_BITS(TOB)
    ) dut (
        .globalclock(globalclock),
        .rst(rst),
        .uart_rx(uart_rx),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .frame_err(frame_err),
        .word_data(word_data),
        .word_valid(word_valid),
        .busy(busy)
    );

    always #5 globalclock = ~globalclock;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0]  exp_bytes[$];
    logic [23:0] exp_words[$];
    int          exp_ferr = 0;
    logic [7:0]  pend[$];
    int          since_bits = 100;
    logic [23:0] model_word = '0;
    logic [7:0]  model_rx = '0;
    int          n_rxv = 0, n_fe = 0, n_wv = 0;
    logic        prev_rxv = 1'b0, prev_fe = 1'b0, prev_wv = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name, input logic [31:0] act);
        vectors++;
        miscompares++;
        $display("FAIL %s: got 0x%0h, nothing expected", name, act);
    endtask

    // Frame-level model: words are three consecutive good bytes with no long gap between them
    task automatic model_frame(input logic [7:0] b, input logic stop_ok, input int gap_bits);
        since_bits += 10;
        if (stop_ok) begin
            if (pend.size() != 0 && since_bits >= TOB) pend.delete();
            exp_bytes.push_back(b);
            pend.push_back(b);
            since_bits = 0;
            if (pend.size() == 3) begin
                exp_words.push_back({pend[0], pend[1], pend[2]});
                pend.delete();
            end
        end else begin
            exp_ferr++;
            pend.delete();
        end
        since_bits += gap_bits;
    endtask

    task automatic send(input logic [7:0] b, input logic stop_bit, input int gap_bits);
        model_frame(b, stop_bit, gap_bits);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge globalclock);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(negedge globalclock);
        end
        uart_rx = stop_bit;
        repeat (CPB) @(negedge globalclock);
        uart_rx = 1'b1;
        repeat (gap_bits * CPB) @(negedge globalclock);
    endtask

    task automatic idle(input int bits);
        uart_rx = 1'b1;
        since_bits += bits;
        repeat (bits * CPB) @(negedge globalclock);
    endtask

    always @(negedge globalclock) begin
        if (rst) begin
            model_word = '0;
            model_rx   = '0;
            prev_rxv   = 1'b0;
            prev_fe    = 1'b0;
            prev_wv    = 1'b0;
        end else begin
            if (rx_valid || frame_err || word_valid) begin
                check("rx_valid_and_frame_err_exclusive", {31'd0, rx_valid & frame_err}, 32'd0);
                check("pulse_single_cycle",
                      {31'd0, (rx_valid & prev_rxv) | (frame_err & prev_fe) | (word_valid & prev_wv)}, 32'd0);
            end
            if (rx_valid) begin
                n_rxv++;
                if (exp_bytes.size() == 0) flag("unexpected_rx_valid", {24'd0, rx_data});
                else begin
                    model_rx = exp_bytes.pop_front();
                    check("rx_data", {24'd0, rx_data}, {24'd0, model_rx});
                end
            end
            if (word_valid) begin
                n_wv++;
                check("word_valid_with_rx_valid", {31'd0, rx_valid}, 32'd1);
                if (exp_words.size() == 0) flag("unexpected_word_valid", {8'd0, word_data});
                else model_word = exp_words.pop_front();
            end
            if (rx_valid || word_valid) check("word_data", {8'd0, word_data}, {8'd0, model_word});
            if (frame_err) begin
                n_fe++;
                if (exp_ferr == 0) flag("unexpected_frame_err", {24'd0, rx_data});
                else exp_ferr--;
                check("rx_data_hold_on_frame_err", {24'd0, rx_data}, {24'd0, model_rx});
            end
            prev_rxv = rx_valid;
            prev_fe  = frame_err;
            prev_wv  = word_valid;
        end
    end

    initial begin
        int b_rxv, b_fe, b_wv;

        rst = 1'b1;
        uart_rx = 1'b1;
        repeat (5) @(negedge globalclock);
        check("reset_rx_data", {24'd0, rx_data}, 32'h0);
        check("reset_word_data", {8'd0, word_data}, 32'h0);
        check("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("reset_frame_err", {31'd0, frame_err}, 32'd0);
        check("reset_word_valid", {31'd0, word_valid}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge globalclock);

        // single byte
        b_rxv = n_rxv; b_fe = n_fe;
        send(8'hA5, 1'b1, 0);
        check("a5_busy_after_stop", {31'd0, busy}, 32'd0);
        repeat (4) @(negedge globalclock);
        check("a5_rx_data", {24'd0, rx_data}, 32'hA5);
        check("a5_rx_valid_count", n_rxv - b_rxv, 32'd1);
        check("a5_frame_err_count", n_fe - b_fe, 32'd0);
        idle(30);

        // three back-to-back bytes make one word
        b_rxv = n_rxv; b_wv = n_wv;
        send(8'h12, 1'b1, 0);
        send(8'h34, 1'b1, 0);
        send(8'h56, 1'b1, 0);
        check("word1_rx_valid_count", n_rxv - b_rxv, 32'd3);
        check("word1_word_valid_count", n_wv - b_wv, 32'd1);
        check("word1_word_data", {8'd0, word_data}, 32'h123456);
        idle(30);

        // glitch shorter than half a bit
        b_rxv = n_rxv; b_fe = n_fe;
        uart_rx = 1'b0;
        repeat (8) @(negedge globalclock);
        check("glitch_busy_during", {31'd0, busy}, 32'd1);
        repeat (2) @(negedge globalclock);
        idle(3);
        check("glitch_busy_after", {31'd0, busy}, 32'd0);
        check("glitch_rx_valid_count", n_rxv - b_rxv, 32'd0);
        check("glitch_frame_err_count", n_fe - b_fe, 32'd0);
        idle(30);

        // framing error discards the partial word
        b_fe = n_fe; b_wv = n_wv;
        send(8'h12, 1'b1, 0);
        send(8'h34, 1'b0, 2);
        send(8'h56, 1'b1, 0);
        send(8'h78, 1'b1, 0);
        send(8'h9A, 1'b1, 0);
        check("ferr_frame_err_count", n_fe - b_fe, 32'd1);
        check("ferr_word_valid_count", n_wv - b_wv, 32'd1);
        check("ferr_word_data", {8'd0, word_data}, 32'h56789A);
        idle(30);

        // inter-byte timeout drops the first pair
        b_wv = n_wv;
        send(8'hAB, 1'b1, 0);
        send(8'hCD, 1'b1, 25);
        check("timeout_no_word_yet", n_wv - b_wv, 32'd0);
        send(8'h01, 1'b1, 0);
        send(8'h02, 1'b1, 0);
        send(8'h03, 1'b1, 0);
        check("timeout_word_valid_count", n_wv - b_wv, 32'd1);
        check("timeout_word_data", {8'd0, word_data}, 32'h010203);
        idle(5);

        // reset in data bit 4 of 0xFF
        b_rxv = n_rxv; b_fe = n_fe;
        uart_rx = 1'b0;
        repeat (CPB) @(negedge globalclock);
        uart_rx = 1'b1;
        repeat (4 * CPB + CPB / 2) @(negedge globalclock);
        rst = 1'b1;
        pend.delete();
        since_bits = 100;
        repeat (3) @(negedge globalclock);
        check("midreset_rx_data", {24'd0, rx_data}, 32'h0);
        check("midreset_word_data", {8'd0, word_data}, 32'h0);
        check("midreset_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        repeat (6 * CPB) @(negedge globalclock);
        check("aborted_byte_no_output", (n_rxv - b_rxv) + (n_fe - b_fe), 32'd0);
        send(8'h3C, 1'b1, 2);
        check("after_reset_rx_data", {24'd0, rx_data}, 32'h3C);
        check("after_reset_rx_valid_count", n_rxv - b_rxv, 32'd1);
        check("after_reset_frame_err_count", n_fe - b_fe, 32'd0);

        check("pending_bytes_left", exp_bytes.size(), 32'd0);
        check("pending_words_left", exp_words.size(), 32'd0);
        check("pending_frame_errs_left", exp_ferr, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
